// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Instruction encoder and program loader for the single-cycle MIPS core.
//   Accepts instruction descriptors over a valid/ready handshake, packs each
//   one into a 32-bit MIPS word, buffers the words in a small FIFO and writes
//   them sequentially into instruction memory from a programmable address.
//
// Parameters
//   DEPTH   encoded-word FIFO depth (power of 2, >= 2)
//   ADDR_W  IMEM word-address width
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   start       pulse: load write address, flush FIFO, clear count/err
//   start_addr  first IMEM word address, sampled on start
//   in_valid    descriptor valid
//   in_ready    encoder can accept a descriptor
//   in_op       mnemonic enum (0..18 legal, 19..31 illegal)
//   in_rs/in_rt/in_rd/in_sa  register / shift fields
//   in_imm      16-bit immediate
//   in_target   26-bit jump target field
//   im_we       IMEM write request
//   im_addr     IMEM word address
//   im_wdata    encoded instruction
//   im_ready    IMEM accepts the write this cycle
//   count       words written since start, saturating
//   err_illegal sticky flag: an undefined in_op was accepted
//   busy        FIFO non-empty
//   checksum    running XOR of completed write data
//
// Build option
//   ENC_CHECKSUM_EN  when defined, checksum is a real XOR accumulator;
//                    otherwise the port is tied to zero.
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ready,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              busy,
  output logic [31:0]       checksum
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic              full;
  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic [31:0]       enc_word;

  // Pack a descriptor into a MIPS word. Fields a format does not use are
  // forced to zero (sa for ALU R-type, rs for shifts and LUI).
  function automatic logic [31:0] encode(input logic [4:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  sa,
                                         input logic [15:0] imm,
                                         input logic [25:0] tgt);
    logic [31:0] w;
    w = '0;
    case (op)
      5'd0:  w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd1:  w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      5'd2:  w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      5'd3:  w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      5'd4:  w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      5'd5:  w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      5'd6:  w = {6'h00, rs, rt, rd, 5'd0, 6'h26};
      5'd7:  w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5'd8:  w = {6'h00, 5'd0, rt, rd, sa, 6'h00};
      5'd9:  w = {6'h00, 5'd0, rt, rd, sa, 6'h02};
      5'd10: w = {6'h08, rs, rt, imm};
      5'd11: w = {6'h09, rs, rt, imm};
      5'd12: w = {6'h0D, rs, rt, imm};
      5'd13: w = {6'h23, rs, rt, imm};
      5'd14: w = {6'h2B, rs, rt, imm};
      5'd15: w = {6'h04, rs, rt, imm};
      5'd16: w = {6'h0F, 5'd0, rt, imm};
      5'd17: w = {6'h02, tgt};
      5'd18: w = {6'h03, tgt};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= 5'd18);
  endfunction

  // Handshake decode. in_ready looks at the registered occupancy only, so a
  // pop in a full cycle frees a slot for the following cycle.
  always_comb begin
    full     = (occ_q == OCC_FULL);
    in_ready = !full && !start;
    accept   = in_valid && in_ready;
    legal    = op_legal(in_op);
    push     = accept && legal;
    pop      = (state_q == S_EMIT) && im_ready && !start;
    enc_word = encode(in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
  end

  // Next-state logic; start overrides every other update.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      addr_d   = start_addr;
      count_d  = '0;
      err_d    = 1'b0;
      state_d  = S_IDLE;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        addr_d   = addr_q + ADDR_W'(1);
        if (count_q != '1) begin
          count_d = count_q + (ADDR_W+1)'(1);
        end
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
      if (accept && !legal) begin
        err_d = 1'b1;
      end
      // Looking at the post-edge occupancy lets a word pushed into an empty
      // FIFO be presented to IMEM one cycle after its accept.
      state_d = (occ_d != '0) ? S_EMIT : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign im_we       = (state_q == S_EMIT);
  assign im_addr     = addr_q;
  assign im_wdata    = im_we ? mem_q[rd_ptr_q] : 32'h0;
  assign count       = count_q;
  assign err_illegal = err_q;
  assign busy        = (occ_q != '0);

`ifdef ENC_CHECKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start) begin
      cksum_d = '0;
    end else if (pop) begin
      cksum_d = cksum_q ^ im_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//   Scoreboard bench for inst_encoder. The stimulus process pushes the
//   expected word of every accepted legal descriptor into a queue; a monitor
//   on the falling edge compares the IMEM write port, handshake and status
//   outputs against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int CNT_MAX = (1 << (ADDR_W + 1)) - 1;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op, in_rs, in_rt, in_rd, in_sa;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              im_ready;
  logic [ADDR_W:0]   count;
  logic              err_illegal;
  logic              busy;
  logic [31:0]       checksum;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ready(im_ready),
    .count(count), .err_illegal(err_illegal), .busy(busy), .checksum(checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] wlog[$];
  int          alog[$];
  int          m_addr;
  int          m_count;
  logic        m_err;
  logic [31:0] m_ck;
  int          n_checks;
  int          n_fail;
  logic        rnd_en;

  int unsigned rfun[8] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h2A};
  int unsigned iopc[6] = '{32'h08, 32'h09, 32'h0D, 32'h23, 32'h2B, 32'h04};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // MIPS field packing computed arithmetically from the mnemonic tables.
  function automatic logic [31:0] m_enc(input int unsigned op, input int unsigned rs,
                                        input int unsigned rt, input int unsigned rd,
                                        input int unsigned sa, input int unsigned imm,
                                        input int unsigned tgt);
    int unsigned w;
    if (op < 8)        w = (rs << 21) + (rt << 16) + (rd << 11) + rfun[op];
    else if (op == 8)  w = (rt << 16) + (rd << 11) + (sa << 6);
    else if (op == 9)  w = (rt << 16) + (rd << 11) + (sa << 6) + 2;
    else if (op < 16)  w = (iopc[op-10] << 26) + (rs << 21) + (rt << 16) + imm;
    else if (op == 16) w = (32'h0F << 26) + (rt << 16) + imm;
    else               w = ((op - 15) << 26) + tgt;
    return w;
  endfunction

  function automatic logic [31:0] exp_ck();
`ifdef ENC_CHECKSUM_EN
    return m_ck;
`else
    return 32'h0;
`endif
  endfunction

  // Monitor: compares every falling edge, then retires a completed write.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < DEPTH) && !start});
      chk("im_we", {31'b0, im_we}, {31'b0, q.size() != 0});
      chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
      chk("count", 32'(count), 32'(m_count));
      chk("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
      chk("checksum", checksum, exp_ck());
      if (im_we && q.size() != 0) begin
        chk("im_addr", 32'(im_addr), 32'(m_addr));
        chk("im_wdata", im_wdata, q[0]);
        if (im_ready && !start) begin
          wlog.push_back(im_wdata);
          alog.push_back(int'(im_addr));
          m_ck = m_ck ^ q[0];
          void'(q.pop_front());
          m_addr = (m_addr + 1) & AMASK;
          if (m_count < CNT_MAX) m_count++;
        end
      end
    end
  end

  // All driver tasks begin and end just after a rising edge.
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int sa, input int imm, input int tgt);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_sa = sa[4:0]; in_imm = imm[15:0]; in_target = tgt[25:0];
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
    end
    @(posedge clk);
    if (ok) begin
      if (op <= 18) q.push_back(m_enc(op, rs, rt, rd, sa, imm, tgt));
      else m_err = 1'b1;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !im_we) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still pending", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int a);
    start = 1'b1;
    start_addr = a[ADDR_W-1:0];
    @(posedge clk);
    q.delete();
    m_addr = a & AMASK; m_count = 0; m_err = 1'b0; m_ck = '0;
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    q.delete();
    m_addr = 0; m_count = 0; m_err = 1'b0; m_ck = '0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_rand(input bit allow_illegal);
    int op;
    if (allow_illegal && $urandom_range(0, 9) == 0) op = 19 + $urandom_range(0, 12);
    else op = $urandom_range(0, 18);
    send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
  endtask

  // Random IMEM back-pressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) im_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; rnd_en = 1'b0;
    start = 1'b0; start_addr = '0; in_valid = 1'b0; im_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_sa = '0; in_imm = '0; in_target = '0;
    m_addr = 0; m_count = 0; m_err = 1'b0; m_ck = '0;
    rst_n = 1'b0;
    #1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_im_we", {31'b0, im_we}, 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);
    chk("rst_im_wdata", im_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_err", {31'b0, err_illegal}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // ADD with sa ignored, then ADDI / LUI / SLL
    im_ready = 1'b1;
    do_start(32'h010);
    wlog.delete(); alog.delete();
    send(0, 1, 2, 3, 7, 0, 0);
    wait_idle();
    chk("add_addr", 32'(alog[0]), 32'h010);
    chk("add_word", wlog[0], 32'h00221820);
    chk("add_count", 32'(count), 32'h1);
    send(10, 0, 8, 0, 0, 16'hFFFF, 0);
    send(16, 5, 1, 0, 0, 16'h1234, 0);
    send(8, 9, 3, 2, 4, 0, 0);
    wait_idle();
    chk("addi_word", wlog[1], 32'h2008FFFF);
    chk("lui_word", wlog[2], 32'h3C011234);
    chk("sll_word", wlog[3], 32'h00031100);
    chk("sll_addr", 32'(alog[3]), 32'h013);

    // Back-pressure: DEPTH+1 descriptors with IMEM stalled
    wlog.delete();
    im_ready = 1'b0;
    fork
      begin
        send(15, 1, 2, 0, 0, 3, 0);
        send(17, 0, 0, 0, 0, 0, 32'h0100000);
        send(5, 4, 5, 6, 0, 0, 0);
        send(12, 7, 8, 0, 0, 16'hBEEF, 0);
        send(18, 0, 0, 0, 0, 0, 32'h3FFFFFF);
      end
      begin
        repeat (8) @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        chk("full_stall_we", {31'b0, im_we}, 32'h1);
        @(posedge clk);
        #1;
        im_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_nwords", 32'(wlog.size()), 32'd5);
    chk("beq_word", wlog[0], 32'h10220003);
    chk("j_word", wlog[1], 32'h08100000);

    // Address wrap
    do_start(AMASK);
    alog.delete();
    send(1, 1, 1, 1, 0, 0, 0);
    send(11, 2, 2, 0, 0, 5, 0);
    wait_idle();
    chk("wrap_first", 32'(alog[0]), 32'(AMASK));
    chk("wrap_second", 32'(alog[1]), 32'h0);

    // Illegal opcode
    wlog.delete();
    send(25, 1, 2, 3, 0, 0, 0);
    @(negedge clk);
    chk("illegal_err", {31'b0, err_illegal}, 32'h1);
    chk("illegal_nowrite", {31'b0, im_we}, 32'h0);
    @(posedge clk);
    #1;
    do_start(0);
    @(negedge clk);
    chk("start_clears_err", {31'b0, err_illegal}, 32'h0);
    @(posedge clk);
    #1;

    // start with 3 words buffered and IMEM ready in the start cycle
    im_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    send(2, 4, 5, 6, 0, 0, 0);
    send(7, 7, 8, 9, 0, 0, 0);
    im_ready = 1'b1;
    do_start(5);
    @(negedge clk);
    chk("flush_im_we", {31'b0, im_we}, 32'h0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_addr", 32'(im_addr), 32'h5);
    @(posedge clk);
    #1;

    // Checksum of ADD then ADDI
    do_start(0);
    send(0, 1, 2, 3, 7, 0, 0);
    send(10, 0, 8, 0, 0, 16'hFFFF, 0);
    wait_idle();
`ifdef ENC_CHECKSUM_EN
    chk("checksum_pair", checksum, 32'h202AE7DF);
`else
    chk("checksum_tied", checksum, 32'h0);
`endif

    // Random traffic with back-pressure and a reset mid-stream
    do_start($urandom_range(0, AMASK));
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      send_rand(1'b1);
    end
    rnd_en = 1'b0;
    im_ready = 1'b1;
    wait_idle();

    // Count saturation (and address wrap) over a long stream
    do_start(0);
    for (int i = 0; i < CNT_MAX + 3; i++) send_rand(1'b0);
    wait_idle();
    chk("count_saturated", 32'(count), 32'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
